m_timer: RTL and testbench

//  Memory-mapped down-counting timer; the interrupt source feeding one hwInt bit of the CP0.

---
 rtl/m_timer.sv | 102 ++++++++++
 tb/tb_m_timer.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/m_timer.sv
// Memory-mapped down-counting timer with one-shot (level) or periodic (pulse) interrupt.
// Registers: 0=CTRL {IM,MODE[1:0],EN}, 1=PRESET, 2=COUNT (read-only), 3=reserved.
module m_timer #(
    parameter int unsigned CNT_W = 32
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [1:0]  addr,
    input  logic        we,
    input  logic [31:0] din,
    output logic [31:0] dout,
    output logic        irq
);

    typedef enum logic [1:0] {StIdle, StLoad, StCnt, StInt} state_e;

    state_e           state_q;
    logic [3:0]       ctrl_q;
    logic [CNT_W-1:0] preset_q;
    logic [CNT_W-1:0] count_q;
    logic             irq_flag_q;

    logic en;
    logic periodic;
    logic ctrl_wr;
    logic preset_wr;

    assign en        = ctrl_q[0];
    assign periodic  = (ctrl_q[2:1] == 2'd1);
    assign ctrl_wr   = we && (addr == 2'd0);
    assign preset_wr = we && (addr == 2'd1);

    // FSM decisions use the registered CTRL, so a write this edge takes effect next edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= StIdle;
            ctrl_q     <= 4'd0;
            preset_q   <= '0;
            count_q    <= '0;
            irq_flag_q <= 1'b0;
        end else begin
            if (preset_wr) begin
                preset_q <= din[CNT_W-1:0];
            end
            // Placed before the FSM so a same-edge hardware set of the flag wins.
            if (ctrl_wr) begin
                irq_flag_q <= 1'b0;
            end

            unique case (state_q)
                StIdle: begin
                    if (en) begin
                        state_q <= StLoad;
                    end
                end
                StLoad: begin
                    count_q <= preset_q;
                    state_q <= en ? StCnt : StIdle;
                end
                StCnt: begin
                    if (!en) begin
                        state_q <= StIdle;
                    end else if (count_q <= CNT_W'(1)) begin
                        count_q    <= '0;
                        irq_flag_q <= 1'b1;
                        state_q    <= StInt;
                    end else begin
                        count_q <= count_q - CNT_W'(1);
                    end
                end
                StInt: begin
                    if (periodic) begin
                        irq_flag_q <= 1'b0;
                        state_q    <= StLoad;
                    end else begin
                        ctrl_q[0] <= 1'b0;
                        state_q   <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase

            // Placed after the FSM so a software write overrides the hardware EN clear.
            if (ctrl_wr) begin
                ctrl_q <= din[3:0];
            end
        end
    end

    always_comb begin
        dout = 32'd0;
        unique case (addr)
            2'd0:    dout = {28'd0, ctrl_q};
            2'd1:    dout = 32'(preset_q);
            2'd2:    dout = 32'(count_q);
            default: dout = 32'd0;
        endcase
    end

    assign irq = irq_flag_q & ctrl_q[3];

endmodule

// File: tb/tb_m_timer.sv
// Directed bench for m_timer: reset, one-shot, periodic, masking, disable and write collisions.
module tb_m_timer;

    logic        clk;
    logic        reset;
    logic [1:0]  addr;
    logic        we;
    logic [31:0] din;
    logic [31:0] dout;
    logic        irq;

    int checks;
    int failures;

    m_timer #(.CNT_W(32)) dut (
        .clk  (clk),
        .reset(reset),
        .addr (addr),
        .we   (we),
        .din  (din),
        .dout (dout),
        .irq  (irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Write lands on the next rising edge; returns 1 time unit after it.
    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        @(negedge clk);
        addr = a;
        din  = d;
        we   = 1'b1;
        @(posedge clk);
        #1;
        we = 1'b0;
    endtask

    task automatic rd(input logic [1:0] a, output logic [31:0] d);
        addr = a;
        #1;
        d = dout;
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    logic [31:0] v;
    int          exp_cnt3 [11] = '{0, 3, 2, 1, 0, 0, 3, 2, 1, 0, 0};
    logic        exp_irq3 [11] = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 1, 0};
    logic        exp_irq6 [6]  = '{0, 0, 1, 0, 0, 1};

    initial begin
        checks   = 0;
        failures = 0;
        reset    = 1'b1;
        addr     = 2'd0;
        we       = 1'b0;
        din      = 32'd0;
        #12;
        rd(2'd0, v); check("rst_ctrl", v, 32'd0);
        rd(2'd1, v); check("rst_preset", v, 32'd0);
        rd(2'd2, v); check("rst_count", v, 32'd0);
        check("rst_irq", {31'd0, irq}, 32'd0);
        @(negedge clk);
        reset = 1'b0;

        // Reset asserted mid-count
        wr(2'd1, 32'd10);
        wr(2'd0, 32'h9);
        tick(4);
        rd(2'd2, v); check("t1_count_pre", v, 32'd8);
        reset = 1'b1;
        #1;
        rd(2'd2, v); check("t1_count_rst", v, 32'd0);
        check("t1_irq_rst", {31'd0, irq}, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        tick(3);
        rd(2'd2, v); check("t1_count_idle", v, 32'd0);
        rd(2'd0, v); check("t1_ctrl_idle", v, 32'd0);

        // Mode 0 one-shot, P=5: irq after edge 7
        wr(2'd1, 32'd5);
        wr(2'd0, 32'h9);
        check("t2_irq_e0", {31'd0, irq}, 32'd0);
        tick(6);
        rd(2'd2, v); check("t2_count_e6", v, 32'd1);
        check("t2_irq_e6", {31'd0, irq}, 32'd0);
        tick(1);
        check("t2_irq_e7", {31'd0, irq}, 32'd1);
        rd(2'd2, v); check("t2_count_e7", v, 32'd0);
        tick(4);
        check("t2_irq_held", {31'd0, irq}, 32'd1);
        rd(2'd0, v); check("t2_ctrl_en_clr", v, 32'h8);
        wr(2'd0, 32'h8);
        check("t2_irq_cleared", {31'd0, irq}, 32'd0);

        // Mode 1 periodic, P=3: period 5
        wr(2'd1, 32'd3);
        wr(2'd0, 32'hB);
        for (int k = 0; k < 11; k++) begin
            tick(1);
            rd(2'd2, v); check($sformatf("t3_count_e%0d", k + 1), v, 32'(exp_cnt3[k]));
            check($sformatf("t3_irq_e%0d", k + 1), {31'd0, irq}, {31'd0, exp_irq3[k]});
        end
        wr(2'd0, 32'h0);
        tick(2);

        // Masked expiry, P=2
        wr(2'd1, 32'd2);
        wr(2'd0, 32'h1);
        tick(5);
        check("t4_irq_masked", {31'd0, irq}, 32'd0);
        rd(2'd0, v); check("t4_ctrl", v, 32'h0);
        rd(2'd2, v); check("t4_count", v, 32'd0);
        wr(2'd0, 32'h8);
        tick(1);
        check("t4_irq_after_im", {31'd0, irq}, 32'd0);

        // Disable mid-count, then P=0 behaves as P=1
        wr(2'd1, 32'd10);
        wr(2'd0, 32'h9);
        tick(6);
        rd(2'd2, v); check("t5_count_e6", v, 32'd6);
        wr(2'd0, 32'h8);
        tick(3);
        rd(2'd2, v); check("t5_count_frozen", v, 32'd5);
        check("t5_irq_none", {31'd0, irq}, 32'd0);
        wr(2'd1, 32'd0);
        wr(2'd0, 32'h9);
        tick(2);
        check("t5_irq_e2", {31'd0, irq}, 32'd0);
        tick(1);
        check("t5_irq_e3", {31'd0, irq}, 32'd1);

        // Collision: CTRL write while in INT beats the EN clear
        wr(2'd0, 32'hB);
        rd(2'd0, v); check("t6_ctrl_kept", v, 32'hB);
        check("t6_irq_cleared", {31'd0, irq}, 32'd0);
        for (int k = 0; k < 6; k++) begin
            tick(1);
            check($sformatf("t6_irq_w%0d", k + 1), {31'd0, irq}, {31'd0, exp_irq6[k]});
        end

        // Collision: CTRL write on the edge that sets the flag; flag set wins
        tick(2);
        wr(2'd0, 32'hB);
        check("t7_flag_wins", {31'd0, irq}, 32'd1);

        // Reset while irq is high: drops immediately
        reset = 1'b1;
        #1;
        check("t8_irq_rst", {31'd0, irq}, 32'd0);
        rd(2'd0, v); check("t8_ctrl_rst", v, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        tick(2);
        check("t8_irq_after", {31'd0, irq}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
